// File: rtl/irr_priority_resolver.sv
// Interrupt request register, mask and rotating-priority resolver of an 8259A-style PIC.
// Drives INT to the CPU and hands the winning IR index to the in-service register on the first INTA.
module irr_priority_resolver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir,
  input  logic       ltim,
  input  logic [7:0] imr,
  input  logic [7:0] isr_value,
  input  logic [2:0] zero_level_index,
  input  logic       ack_first,
  input  logic       ack_done,
  output logic       int_out,
  output logic [2:0] to_set,
  output logic       to_set_valid,
  output logic       spurious,
  output logic [7:0] irr_value
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACKED = 2'd2
  } state_t;

  state_t     stateR;
  state_t     stateNext;
  logic [7:0] irrR;
  logic [7:0] irPrevR;
  logic [7:0] irrNext;
  logic [7:0] candS;
  logic [7:0] rotCandS;
  logic [7:0] rotIsrS;
  logic [2:0] winKS;
  logic       winValidS;
  logic       blockedS;
  logic [2:0] winIdxS;
  logic       grantS;
  logic       strobeS;
  logic [7:0] ackClearS;
  logic       intNext;
  logic [2:0] toSetNext;
  logic       validNext;
  logic       spuriousNext;

  assign candS     = irrR & ~imr;
  assign irr_value = irrR;

  // Resolver: rotate so bit k is priority level k, pick the lowest level, then apply nesting.
  always_comb begin
    rotCandS  = 8'h00;
    rotIsrS   = 8'h00;
    winValidS = 1'b0;
    winKS     = 3'd0;
    blockedS  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rotCandS[k] = candS[3'(zero_level_index + 3'(k))];
      rotIsrS[k]  = isr_value[3'(zero_level_index + 3'(k))];
    end
    for (int k = 7; k >= 0; k--) begin
      if (rotCandS[k]) begin
        winValidS = 1'b1;
        winKS     = 3'(k);
      end else begin
        winValidS = winValidS;
        winKS     = winKS;
      end
    end
    // An in-service level at equal or higher priority holds off the winner.
    for (int k = 0; k < 8; k++) begin
      blockedS = blockedS | (rotIsrS[k] & (3'(k) <= winKS));
    end
    winIdxS = zero_level_index + winKS;
    grantS  = winValidS & ~blockedS;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNext;
    end
  end

  // Next-state logic; INT stays up in REQ even if the request vanishes, as the CPU still acknowledges.
  always_comb begin
    stateNext = stateR;
    case (stateR)
      IDLE:    stateNext = grantS ? REQ : IDLE;
      REQ:     stateNext = ack_first ? ACKED : REQ;
      ACKED:   stateNext = ack_done ? IDLE : ACKED;
      default: stateNext = IDLE;
    endcase
  end

  // Output and IRR next values.
  always_comb begin
    strobeS      = (stateR == REQ) & ack_first;
    intNext      = (stateNext == REQ);
    validNext    = strobeS;
    spuriousNext = strobeS & ~grantS;
    toSetNext    = strobeS ? (grantS ? winIdxS : 3'd7) : to_set;
    ackClearS    = (strobeS & grantS & ~ltim) ? (8'h01 << winIdxS) : 8'h00;
    if (ltim) begin
      irrNext = ir;
    end else begin
      irrNext = (irrR | (ir & ~irPrevR)) & ir & ~ackClearS;
    end
  end

  // IRR and edge-detect registers; ir_prev resets high so lines held through reset do not fire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irrR    <= 8'h00;
      irPrevR <= 8'hFF;
    end else begin
      irrR    <= irrNext;
      irPrevR <= ir;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int_out      <= 1'b0;
      to_set       <= 3'd0;
      to_set_valid <= 1'b0;
      spurious     <= 1'b0;
    end else begin
      int_out      <= intNext;
      to_set       <= toSetNext;
      to_set_valid <= validNext;
      spurious     <= spuriousNext;
    end
  end

endmodule

// File: tb/tb_irr_priority_resolver.sv
// Self-checking bench for irr_priority_resolver: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the IRR and acknowledge protocol.
module tb_irr_priority_resolver;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] ir;
  logic       ltim;
  logic [7:0] imr;
  logic [7:0] isrValue;
  logic [2:0] zli;
  logic       ackFirst;
  logic       ackDone;
  logic       intOut;
  logic [2:0] toSet;
  logic       toSetValid;
  logic       spurious;
  logic [7:0] irrValue;

  int passCnt  = 0;
  int totalCnt = 0;

  // model state
  logic [7:0] mIrr;
  logic [7:0] mPrev;
  int         mPhase;
  logic       mInt;
  logic [2:0] mToSet;
  logic       mValid;
  logic       mSpur;

  irr_priority_resolver dut (
    .clk              (clk),
    .rst_n            (rstN),
    .ir               (ir),
    .ltim             (ltim),
    .imr              (imr),
    .isr_value        (isrValue),
    .zero_level_index (zli),
    .ack_first        (ackFirst),
    .ack_done         (ackDone),
    .int_out          (intOut),
    .to_set           (toSet),
    .to_set_valid     (toSetValid),
    .spurious         (spurious),
    .irr_value        (irrValue)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    totalCnt = totalCnt + 1;
    assert (obs === exp) passCnt = passCnt + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Winning IR index or -1 when nothing requests or the winner is held off by service.
  function automatic int modelWinner(input logic [7:0] irrV, input logic [7:0] imrV,
                                     input logic [7:0] isrV, input logic [2:0] z);
    int zi;
    int bestK;
    zi    = int'(z);
    bestK = -1;
    for (int k = 0; k < 8; k++) begin
      if (bestK < 0 && irrV[(zi + k) % 8] && !imrV[(zi + k) % 8]) bestK = k;
    end
    if (bestK < 0) return -1;
    for (int k = 0; k <= bestK; k++) begin
      if (isrV[(zi + k) % 8]) return -1;
    end
    return (zi + bestK) % 8;
  endfunction

  task automatic modelStep();
    int w;
    int ackIdx;
    if (!rstN) begin
      mIrr = 8'h00; mPrev = 8'hFF; mPhase = 0;
      mInt = 1'b0; mToSet = 3'd0; mValid = 1'b0; mSpur = 1'b0;
      return;
    end
    w      = modelWinner(mIrr, imr, isrValue, zli);
    ackIdx = -1;
    mValid = 1'b0;
    mSpur  = 1'b0;
    case (mPhase)
      0: if (w >= 0) mPhase = 1;
      1: if (ackFirst) begin
           mValid = 1'b1;
           if (w >= 0) begin mToSet = 3'(w); ackIdx = w; end
           else begin mToSet = 3'd7; mSpur = 1'b1; end
           mPhase = 2;
         end
      default: if (ackDone) mPhase = 0;
    endcase
    if (ltim) mIrr = ir;
    else begin
      for (int n = 0; n < 8; n++) begin
        if (!ir[n] || n == ackIdx) mIrr[n] = 1'b0;
        else if (!mPrev[n]) mIrr[n] = 1'b1;
      end
    end
    mPrev = ir;
    mInt  = (mPhase == 1);
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    chk("m_int_out",  {7'd0, intOut},     {7'd0, mInt});
    chk("m_to_set",   {5'd0, toSet},      {5'd0, mToSet});
    chk("m_valid",    {7'd0, toSetValid}, {7'd0, mValid});
    chk("m_spurious", {7'd0, spurious},   {7'd0, mSpur});
    chk("m_irr",      irrValue,           mIrr);
  endtask

  task automatic resetDut();
    rstN = 1'b0; ackFirst = 1'b0; ackDone = 1'b0;
    tick();
    rstN = 1'b1;
  endtask

  initial begin
    rstN = 1'b0; ir = 8'h00; ltim = 1'b0; imr = 8'h00; isrValue = 8'h00;
    zli = 3'd0; ackFirst = 1'b0; ackDone = 1'b0;
    tick();
    tick();
    chk("rst_int", {7'd0, intOut}, 8'h00);
    chk("rst_irr", irrValue, 8'h00);
    chk("rst_valid", {7'd0, toSetValid}, 8'h00);
    rstN = 1'b1;

    // edge request on IR3
    tick();
    ir = 8'h08; tick();
    chk("t1_irr", irrValue, 8'h08);
    chk("t1_int_early", {7'd0, intOut}, 8'h00);
    tick();
    chk("t1_int", {7'd0, intOut}, 8'h01);
    ackFirst = 1'b1; tick(); ackFirst = 1'b0;
    chk("t1_to_set", {5'd0, toSet}, 8'h03);
    chk("t1_valid", {7'd0, toSetValid}, 8'h01);
    chk("t1_irr_clr", irrValue, 8'h00);
    chk("t1_int_low", {7'd0, intOut}, 8'h00);
    tick();
    chk("t1_valid_1cyc", {7'd0, toSetValid}, 8'h00);

    // rotation and mask, level mode so acks keep the IRR
    resetDut();
    ltim = 1'b1; zli = 3'd5; ir = 8'h82; tick();
    chk("t2_irr", irrValue, 8'h82);
    tick();
    ackFirst = 1'b1; tick(); ackFirst = 1'b0;
    chk("t2_win7", {5'd0, toSet}, 8'h07);
    ackDone = 1'b1; tick(); ackDone = 1'b0;
    imr = 8'h80; tick();
    chk("t2_int_masked", {7'd0, intOut}, 8'h01);
    ackFirst = 1'b1; tick(); ackFirst = 1'b0;
    chk("t2_win1", {5'd0, toSet}, 8'h01);
    chk("t2_spur_no", {7'd0, spurious}, 8'h00);

    // fully nested: IR2 in service blocks IR5 but not IR1
    imr = 8'h00; ltim = 1'b0; zli = 3'd0; ir = 8'h00;
    resetDut();
    isrValue = 8'h04; tick();
    ir = 8'h20; tick(); tick(); tick();
    chk("t3_blocked", {7'd0, intOut}, 8'h00);
    ir = 8'h22; tick(); tick();
    chk("t3_int", {7'd0, intOut}, 8'h01);
    ackFirst = 1'b1; tick(); ackFirst = 1'b0;
    chk("t3_to_set", {5'd0, toSet}, 8'h01);
    chk("t3_irr", irrValue, 8'h20);

    // spurious: request vanishes before the acknowledge
    isrValue = 8'h00; ir = 8'h00;
    resetDut();
    tick();
    ir = 8'h10; tick(); tick();
    ir = 8'h00; tick();
    chk("t4_int_held", {7'd0, intOut}, 8'h01);
    ackFirst = 1'b1; tick(); ackFirst = 1'b0;
    chk("t4_to_set", {5'd0, toSet}, 8'h07);
    chk("t4_valid", {7'd0, toSetValid}, 8'h01);
    chk("t4_spur", {7'd0, spurious}, 8'h01);
    tick();
    chk("t4_spur_1cyc", {7'd0, spurious}, 8'h00);

    // level mode re-assert, then reset in REQ
    resetDut();
    ltim = 1'b1; ir = 8'h40; tick(); tick();
    ackFirst = 1'b1; tick(); ackFirst = 1'b0;
    chk("t5_to_set", {5'd0, toSet}, 8'h06);
    chk("t5_irr_kept", irrValue, 8'h40);
    ackDone = 1'b1; tick(); ackDone = 1'b0;
    chk("t5_int_idle", {7'd0, intOut}, 8'h00);
    tick();
    chk("t5_int_reassert", {7'd0, intOut}, 8'h01);
    rstN = 1'b0; tick();
    chk("t5_rst_int", {7'd0, intOut}, 8'h00);
    chk("t5_rst_irr", irrValue, 8'h00);
    chk("t5_rst_to_set", {5'd0, toSet}, 8'h00);
    ltim = 1'b0; rstN = 1'b1;
    tick(); tick(); tick();
    chk("t5_no_edge_irr", irrValue, 8'h00);
    chk("t5_no_edge_int", {7'd0, intOut}, 8'h00);

    // randomized traffic against the model
    for (int c = 0; c < 1200; c++) begin
      if (c % 300 == 0) ltim = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 3) == 0) ir = 8'($urandom);
      if ($urandom_range(0, 15) == 0) imr = 8'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) isrValue = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 31) == 0) zli = 3'($urandom);
      ackFirst = $urandom_range(0, 4) == 0;
      ackDone  = $urandom_range(0, 3) == 0;
      rstN     = $urandom_range(0, 99) != 0;
      tick();
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
